// File: rtl/perf_timer_bank.sv
// Memory-mapped countdown timer with free-running cycle counter and level irq.
// Optional PERF_TIMER_AUTORELOAD_EN: expiry reloads COUNT from LOAD and stays in RUN.
module perf_timer_bank #(
  parameter logic [63:0] BASE_WORD = 64'h0000_0000_2000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        perf_en,
  input  logic        perf_wren,
  input  logic [63:0] perf_addr,
  input  logic [63:0] perf_data,
  output logic [63:0] rd_data,
  output logic        rd_valid,
  output logic        irq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] EXPD = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_n;
  logic [63:0] load;
  logic [63:0] count;
  logic [63:0] count_n;
  logic [63:0] cycle;
  logic        irq_en;
  logic        expired;
  logic        exp_set;
  logic [63:0] rd_mux;

  logic       hit;
  logic [1:0] off;
  logic       rd_hit;
  logic       wr_hit;
  logic       wr_ctrl;
  logic       start;
  logic       stop;
  logic       clr;

  assign hit     = perf_en & (perf_addr[63:2] == BASE_WORD[63:2]);
  assign off     = perf_addr[1:0];
  assign rd_hit  = hit & ~perf_wren;
  assign wr_hit  = hit & perf_wren;
  assign wr_ctrl = wr_hit & (off == 2'd0);
  assign start   = wr_ctrl & perf_data[0];
  assign stop    = wr_ctrl & perf_data[1];
  assign clr     = wr_ctrl & perf_data[3];

  // Arming with LOAD==0 goes straight to EXPIRED; COUNT takes LOAD either way.
  always_comb begin
    state_n = state;
    count_n = count;
    exp_set = 1'b0;
    case (state)
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (start) begin
          count_n = load;
          if (load == 64'd0) begin
            state_n = EXPD;
            exp_set = 1'b1;
          end
        end else if (count > 64'd1) begin
          count_n = count - 64'd1;
        end else begin
          exp_set = 1'b1;
`ifdef PERF_TIMER_AUTORELOAD_EN
          count_n = load;
          if (load == 64'd0) begin
            state_n = EXPD;
          end
`else
          count_n = 64'd0;
          state_n = EXPD;
`endif
        end
      end
      IDLE, EXPD: begin
        if (stop) begin
          state_n = IDLE;
        end else if (start) begin
          count_n = load;
          if (load == 64'd0) begin
            state_n = EXPD;
            exp_set = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_mux = 64'd0;
    case (off)
      2'd0: rd_mux = {58'd0, state, expired, irq_en, 2'b00};
      2'd1: rd_mux = load;
      2'd2: rd_mux = count;
      2'd3: rd_mux = cycle;
      default: rd_mux = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      load     <= 64'd0;
      count    <= 64'd0;
      cycle    <= 64'd0;
      irq_en   <= 1'b0;
      expired  <= 1'b0;
      rd_data  <= 64'd0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      rd_valid <= rd_hit;
      rd_data  <= rd_hit ? rd_mux : 64'd0;
      // Set wins over a simultaneous write-1-clear.
      expired  <= exp_set | (expired & ~clr);
      if (wr_ctrl) begin
        irq_en <= perf_data[2];
      end
      if (wr_hit && off == 2'd1) begin
        load <= perf_data;
      end
      if (wr_hit && off == 2'd3) begin
        cycle <= perf_data;
      end else begin
        cycle <= cycle + 64'd1;
      end
    end
  end

  assign irq = expired & irq_en;

endmodule

// File: tb/tb_perf_timer_bank.sv
// Randomized bench for perf_timer_bank against a behavioural register model.
// Directed sequences cover countdown, read latency, misses, races and async reset.
module tb_perf_timer_bank;

  localparam logic [63:0] BASE = 64'h0000_0000_2000_0000;

  logic        clk;
  logic        rst;
  logic        perf_en;
  logic        perf_wren;
  logic [63:0] perf_addr;
  logic [63:0] perf_data;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        irq;

  int errors = 0;
  int checks = 0;

  perf_timer_bank dut (
    .clk(clk),
    .rst(rst),
    .perf_en(perf_en),
    .perf_wren(perf_wren),
    .perf_addr(perf_addr),
    .perf_data(perf_data),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 running, 2 expired
  int          m_state;
  logic [63:0] m_load;
  logic [63:0] m_count;
  logic [63:0] m_cycle;
  bit          m_irq_en;
  bit          m_exp;
  logic [63:0] m_rd_data;
  bit          m_rd_valid;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_load = 0;
    m_count = 0;
    m_cycle = 0;
    m_irq_en = 0;
    m_exp = 0;
    m_rd_data = 0;
    m_rd_valid = 0;
  endtask

  function automatic logic [63:0] reg_value(input int idx);
    case (idx)
      0: return 64'(m_state) * 16 + 64'(m_exp) * 8 + 64'(m_irq_en) * 4;
      1: return m_load;
      2: return m_count;
      default: return m_cycle;
    endcase
  endfunction

  // Arm the timer: an empty LOAD expires immediately.
  task automatic arm(output bit fired);
    m_count = m_load;
    fired = (m_load == 0);
    m_state = fired ? 2 : 1;
  endtask

  task automatic model_step(input bit en, input bit wr,
                            input logic [63:0] addr, input logic [63:0] data);
    bit hit;
    int idx;
    bit ctrl_w;
    bit fired;
    hit = en && ((addr >> 2) == (BASE >> 2));
    idx = int'(addr % 4);
    m_rd_valid = hit && !wr;
    m_rd_data = m_rd_valid ? reg_value(idx) : 64'd0;
    ctrl_w = hit && wr && idx == 0;
    fired = 0;
    if (ctrl_w && data[1]) begin
      m_state = 0;
    end else if (ctrl_w && data[0]) begin
      arm(fired);
    end else if (m_state == 1) begin
      if (m_count > 1) begin
        m_count = m_count - 1;
      end else begin
        fired = 1;
`ifdef PERF_TIMER_AUTORELOAD_EN
        arm(fired);
        fired = 1;
`else
        m_count = 0;
        m_state = 2;
`endif
      end
    end
    if (fired) m_exp = 1;
    else if (ctrl_w && data[3]) m_exp = 0;
    if (ctrl_w) m_irq_en = data[2];
    if (hit && wr && idx == 1) m_load = data;
    if (hit && wr && idx == 3) m_cycle = data;
    else m_cycle = m_cycle + 1;
  endtask

  task automatic cyc(input bit en, input bit wr, input logic [63:0] addr,
                     input logic [63:0] data);
    perf_en = en;
    perf_wren = wr;
    perf_addr = addr;
    perf_data = data;
    @(posedge clk);
    #1;
    model_step(en, wr, addr, data);
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    chk("rd_data", rd_data, m_rd_data);
    chk("irq", 64'(irq), 64'(m_irq_en & m_exp));
  endtask

  task automatic rd(input int idx);
    cyc(1, 0, BASE + 64'(idx), 64'd0);
  endtask

  task automatic wr(input int idx, input logic [63:0] d);
    cyc(1, 1, BASE + 64'(idx), d);
  endtask

  task automatic nop();
    cyc(0, 0, 64'd0, 64'd0);
  endtask

  logic [63:0] ctrl_exp_a;
  logic [63:0] ctrl_exp_b;

  initial begin
`ifdef PERF_TIMER_AUTORELOAD_EN
    ctrl_exp_a = 64'h1C;
    ctrl_exp_b = 64'h18;
`else
    ctrl_exp_a = 64'h2C;
    ctrl_exp_b = 64'h28;
`endif
    model_reset();
    rst = 1'b1;
    perf_en = 0;
    perf_wren = 0;
    perf_addr = 0;
    perf_data = 0;
    #12;
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cycle counter after three edges since release
    nop(); nop(); nop();
    rd(3);
    chk("cycle_since_rst", rd_data, 64'd3);
    chk("cycle_rv", 64'(rd_valid), 64'd1);
    nop();
    chk("cycle_rv_low", 64'(rd_valid), 64'd0);

    // Countdown LOAD=3 with irq enabled
    wr(1, 64'd3);
    wr(0, 64'h5);
    rd(2); chk("cnt3", rd_data, 64'd3);
    rd(2); chk("cnt2", rd_data, 64'd2);
    rd(2); chk("cnt1", rd_data, 64'd1);
    chk("irq_on_expiry", 64'(irq), 64'd1);
    rd(0); chk("ctrl_after_expiry", rd_data, ctrl_exp_a);

    // Misses and unqualified writes
    cyc(1, 0, BASE + 64'd4, 64'd0);
    chk("miss_rv", 64'(rd_valid), 64'd0);
    cyc(0, 1, BASE, 64'h2);
    chk("noen_rv", 64'(rd_valid), 64'd0);
    rd(0); chk("ctrl_unchanged", rd_data, ctrl_exp_a);

    // Start+stop together in IDLE stays IDLE
    wr(0, 64'h2);
    wr(0, 64'h8);
    wr(0, 64'h3);
    rd(0); chk("start_stop_idle", rd_data, 64'h0);

    // Clear on the expiry cycle loses to set
    wr(1, 64'd2);
    wr(0, 64'h1);
    nop();
    wr(0, 64'h8);
    rd(0); chk("set_beats_clear", rd_data, ctrl_exp_b);
    wr(0, 64'h2);

    // Async reset mid-countdown
    wr(1, 64'd10);
    wr(0, 64'h5);
    nop(); nop(); nop(); nop();
    rd(2); chk("cnt_before_rst", rd_data, 64'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rd_valid", 64'(rd_valid), 64'd0);
    chk("async_rd_data", rd_data, 64'd0);
    chk("async_irq", 64'(irq), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    rd(0); chk("post_rst_ctrl", rd_data, 64'd0);
    rd(2); chk("post_rst_count", rd_data, 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      int idx;
      logic [63:0] d;
      r = $urandom_range(0, 99);
      idx = $urandom_range(0, 3);
      d = {$urandom, $urandom};
      if (r < 40) begin
        rd(idx);
      end else if (r < 75) begin
        case (idx)
          0: d = 64'($urandom_range(0, 15));
          1: d = 64'($urandom_range(0, 6));
          3: if ($urandom_range(0, 3) == 0)
               d = 64'hFFFF_FFFF_FFFF_FFFC + 64'($urandom_range(0, 3));
          default: ;
        endcase
        if (idx == 0 && $urandom_range(0, 2) != 0) begin
          nop();
        end else begin
          wr(idx, d);
        end
      end else if (r < 88) begin
        cyc(0, 1'($urandom_range(0, 1)), BASE + 64'(idx), d);
      end else if (r < 94) begin
        cyc(1, 1'($urandom_range(0, 1)), BASE + 64'(4 + idx), d);
      end else begin
        cyc(1, 1'($urandom_range(0, 1)), BASE - 64'(1 + idx), d);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_timer_bank.md
PERF_TIMER_BANK -- requirements
Module: perf_timer_bank

Interface
REQ-001 SHALL have parameter BASE_WORD, default 64'h0000_0000_2000_0000, meaning the word address of register 0 (byte address 0x1_0000_0000).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port perf_en  input  1  peripheral access strobe from the peripheral interface stage.
REQ-005 SHALL have port perf_wren  input  1  1 = write, 0 = read; qualified by perf_en.
REQ-006 SHALL have port perf_addr  input  64  word address, byte address shifted right by 3.
REQ-007 SHALL have port perf_data  input  64  write data.
REQ-008 SHALL have port rd_data  output  64  registered read data.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse marking rd_data valid.
REQ-010 SHALL have port irq  output  1  timer interrupt, level.

Function
REQ-011 SHALL decode hit = perf_en & (perf_addr[63:2] == BASE_WORD[63:2]); offset = perf_addr[1:0].
REQ-012 SHALL provide four registers: 0 CTRL, 1 LOAD (R/W), 2 COUNT (read-only), 3 CYCLE (free-running).
REQ-013 SHALL lay out CTRL as: bit0 start (W, reads 0), bit1 stop (W, reads 0), bit2 irq_en (R/W), bit3 expired (sticky, write-1-clear), bits5:4 state (IDLE=0, RUN=1, EXPIRED=2), other bits 0.
REQ-014 SHALL, on a read hit in cycle N, drive rd_data with the register value sampled in cycle N and pulse rd_valid in cycle N+1 only (latency 1).
REQ-015 SHALL drive rd_data = 0 and rd_valid = 0 in any cycle that follows no read hit; writes and misses produce no rd_valid.
REQ-016 SHALL increment CYCLE by 1 every cycle, wrapping 2^64-1 to 0; a CYCLE write loads perf_data, which takes priority over the increment.
REQ-017 SHALL ignore writes to COUNT.
REQ-018 SHALL implement the FSM as follows: IDLE --start--> RUN (COUNT<=LOAD); RUN --stop--> IDLE (COUNT held); RUN with COUNT==1 --> EXPIRED (COUNT<=0, expired<=1); EXPIRED --start--> RUN; EXPIRED --stop--> IDLE.
REQ-019 SHALL decrement COUNT by 1 per cycle while in RUN with COUNT>1.
REQ-020 SHALL, on start with LOAD==0, enter EXPIRED on the next edge with expired<=1 (no RUN cycle).
REQ-021 SHALL let stop win when start and stop are written together.
REQ-022 SHALL, when start arrives in RUN, reload COUNT from LOAD and stay in RUN.
REQ-023 SHALL let set win when an expiry and a write-1-clear of expired occur in the same cycle.
REQ-024 SHALL apply the irq_en bit of a CTRL write regardless of the start/stop bits.
REQ-025 SHALL drive irq = expired & irq_en, both from flops, with no combinational path from the inputs.
REQ-026 SHALL make a LOAD write take effect only at the next start or reload; it does not alter a running COUNT.

Reset
REQ-027 SHALL, on rst assertion, set state IDLE, LOAD/COUNT/CYCLE = 0, irq_en = 0, expired = 0, rd_data = 0, rd_valid = 0, irq = 0.
REQ-028 SHALL abort any access or countdown in progress when rst is asserted mid-operation, with no pending rd_valid after release.
REQ-029 SHALL begin CYCLE counting on the first clk edge after rst deasserts.

Configuration
REQ-030 SHALL, with PERF_TIMER_AUTORELOAD_EN defined, replace the RUN-to-EXPIRED transition with: COUNT<=LOAD, stay in RUN, expired<=1; with LOAD==0, reload yields EXPIRED as in REQ-020.
REQ-031 SHALL, without PERF_TIMER_AUTORELOAD_EN, behave exactly as REQ-018, and state value EXPIRED is reachable.

Verification
REQ-032 SHALL cover: write LOAD=3, CTRL=0x5 -> COUNT reads 3,2,1 on successive cycles, then state=EXPIRED, expired=1, irq=1 on the 4th edge after start.
REQ-033 SHALL cover: read CYCLE at word BASE_WORD+3 -> rd_valid high exactly 1 cycle later with a value equal to cycles since reset release, rd_valid low the next cycle.
REQ-034 SHALL cover: read at BASE_WORD+4 (miss), and write CTRL with perf_en=0 -> rd_valid=0, no state change.
REQ-035 SHALL cover: CTRL write 0x3 while IDLE -> state stays IDLE; CTRL write 0x8 on the expiry cycle -> expired stays 1.
REQ-036 SHALL cover: rst asserted asynchronously mid-countdown (COUNT=5) -> all outputs 0 before the next clk edge, state IDLE.
REQ-037 SHALL cover, with PERF_TIMER_AUTORELOAD_EN: LOAD=2, start -> COUNT 2,1,2,1..., expired set at first wrap, state stays RUN.
